bcd_digit_converter: RTL and testbench

- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Produces the four BCD digit buses (thousands, hundreds, tens, ones) consumed by the four-digit seven-segment display multiplexer.
- Sits between the binary count/score logic and the display controller.
- Digit outputs are registered and held stable between conversions, so the display never shows partial results.

---
 rtl/bcd_digit_converter.sv | 121 ++++++++++++
 tb/tb_bcd_digit_converter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Digit outputs are registered and only change when a conversion completes,
// so a downstream display multiplexer never sees partial results.
module bcd_digit_converter #(
    parameter int unsigned BIN_WIDTH = 14
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic [BIN_WIDTH-1:0] bin_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 overflow_o,
    output logic [3:0]           thousands_o,
    output logic [3:0]           hundreds_o,
    output logic [3:0]           tens_o,
    output logic [3:0]           ones_o
);

    localparam int unsigned      CNT_W    = $clog2(BIN_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] bin_sr;
    logic [15:0]          scratch;
    logic [15:0]          scratch_adj;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 ovf_pending;
    logic                 nibbles_ok;
    logic [31:0]          bin_ext;

    assign bin_ext = 32'(bin_i);

    // Add-3 correction of every scratch nibble >= 5 ahead of the shift;
    // also flags whether every nibble entering the adjust is a legal digit.
    always_comb begin
        scratch_adj = scratch;
        nibbles_ok  = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (scratch[4*i +: 4] > 4'd9) begin
                nibbles_ok = 1'b0;
            end
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM with registered status and digit outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bin_sr      <= '0;
            scratch     <= '0;
            bit_cnt     <= '0;
            ovf_pending <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            overflow_o  <= 1'b0;
            thousands_o <= '0;
            hundreds_o  <= '0;
            tens_o      <= '0;
            ones_o      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        bin_sr      <= bin_i;
                        scratch     <= '0;
                        bit_cnt     <= CNT_LOAD;
                        ovf_pending <= (bin_ext > 32'd9999);
                        busy_o      <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {scratch_adj[14:0], bin_sr[BIN_WIDTH-1]};
                    bin_sr  <= bin_sr << 1;
                    bit_cnt <= bit_cnt - CNT_ONE;
                    if (bit_cnt == CNT_ONE) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (ovf_pending) begin
                        thousands_o <= 4'd9;
                        hundreds_o  <= 4'd9;
                        tens_o      <= 4'd9;
                        ones_o      <= 4'd9;
                    end else begin
                        thousands_o <= scratch[15:12];
                        hundreds_o  <= scratch[11:8];
                        tens_o      <= scratch[7:4];
                        ones_o      <= scratch[3:0];
                    end
                    overflow_o <= ovf_pending;
                    done_o     <= 1'b1;
                    busy_o     <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every nibble fed into the add-3 step must already be a decimal digit.
    nibble_range: assert property (
        @(posedge clock) disable iff (!reset) (state == SHIFT) |-> nibbles_ok
    );

endmodule

// File: tb/tb_bcd_digit_converter.sv
// Self-checking bench for bcd_digit_converter: a cycle-level behavioural
// model (arithmetic div/mod digits) compared every cycle, plus directed
// vectors with hand-computed digits.
module tb_bcd_digit_converter;

    localparam int BW = 14;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic [BW-1:0] bin_i = '0;
    logic          busy_o, done_o, overflow_o;
    logic [3:0]    thousands_o, hundreds_o, tens_o, ones_o;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_digit_converter #(.BIN_WIDTH(BW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_i     (start_i),
        .bin_i       (bin_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .thousands_o (thousands_o),
        .hundreds_o  (hundreds_o),
        .tens_o      (tens_o),
        .ones_o      (ones_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_cnt  = 0;
    int m_cap  = 0;
    int m_busy = 0, m_done = 0, m_ovf = 0;
    int m_th = 0, m_h = 0, m_t = 0, m_o = 0;

    always @(posedge clock or negedge reset) begin
        int v;
        if (!reset) begin
            m_cnt = 0; m_busy = 0; m_done = 0; m_ovf = 0;
            m_th = 0; m_h = 0; m_t = 0; m_o = 0;
        end else begin
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    v     = (m_cap > 9999) ? 9999 : m_cap;
                    m_th  = v / 1000;
                    m_h   = (v / 100) % 10;
                    m_t   = (v / 10) % 10;
                    m_o   = v % 10;
                    m_ovf = (m_cap > 9999) ? 1 : 0;
                    m_done = 1;
                    m_busy = 0;
                end
            end else if (start_i) begin
                m_cap  = int'(bin_i);
                m_cnt  = BW + 1;
                m_busy = 1;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(posedge clock) begin
        #1;
        check("busy", int'(busy_o), m_busy);
        check("done", int'(done_o), m_done);
        check("overflow", int'(overflow_o), m_ovf);
        check("thousands", int'(thousands_o), m_th);
        check("hundreds", int'(hundreds_o), m_h);
        check("tens", int'(tens_o), m_t);
        check("ones", int'(ones_o), m_o);
    end

    // ---------------- directed helpers ----------------
    task automatic wait_done(output int k);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock);
            #1;
            if (done_o) begin
                k = i;
                break;
            end
        end
        if (k == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout: got no done, expected done within 40 edges at %0t", $time);
        end
    endtask

    task automatic check_digits(input string tag, input int th, input int h,
                                input int t, input int o, input int ov);
        check({tag, "_th"}, int'(thousands_o), th);
        check({tag, "_h"}, int'(hundreds_o), h);
        check({tag, "_t"}, int'(tens_o), t);
        check({tag, "_o"}, int'(ones_o), o);
        check({tag, "_ovf"}, int'(overflow_o), ov);
    endtask

    task automatic run_conv(input string tag, input int v, input int th, input int h,
                            input int t, input int o, input int ov);
        int k;
        @(negedge clock);
        start_i = 1'b1;
        bin_i   = BW'(v);
        @(negedge clock);
        start_i = 1'b0;
        bin_i   = BW'($urandom);
        wait_done(k);
        check({tag, "_latency"}, k, 15);
        check_digits(tag, th, h, t, o, ov);
    endtask

    task automatic count_dones(input int cycles, output int nd);
        nd = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clock);
            #1;
            if (done_o) nd++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k, nd, v, e;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;

        // Idle after reset: nothing happens without start.
        count_dones(5, nd);
        check("idle_dones", nd, 0);
        check("idle_busy", int'(busy_o), 0);
        check_digits("idle", 0, 0, 0, 0, 0);

        // Main function and boundaries.
        run_conv("v1234", 1234, 1, 2, 3, 4, 0);
        run_conv("v0", 0, 0, 0, 0, 0, 0);
        run_conv("v9999", 9999, 9, 9, 9, 9, 0);
        run_conv("v10000", 10000, 9, 9, 9, 9, 1);
        run_conv("v16383", 16383, 9, 9, 9, 9, 1);
        run_conv("v305", 305, 0, 3, 0, 5, 0);

        // Start while busy is ignored and not queued.
        @(negedge clock);
        start_i = 1'b1;
        bin_i   = BW'(42);
        @(negedge clock);
        start_i = 1'b0;
        repeat (4) @(negedge clock);
        start_i = 1'b1;
        bin_i   = BW'(7777);
        @(negedge clock);
        start_i = 1'b0;
        wait_done(k);
        check("busy_ign_latency", k, 10);
        check_digits("busy_ign", 0, 0, 4, 2, 0);
        count_dones(20, nd);
        check("busy_ign_extra_done", nd, 0);

        // start held high: a conversion every 16 cycles.
        @(negedge clock);
        start_i = 1'b1;
        bin_i   = BW'(2000);
        count_dones(80, nd);
        for (int i = 0; i < 0; i++) bin_i = bin_i + 1'b1;
        check("held_dones", nd, 5);
        @(negedge clock);
        start_i = 1'b0;
        count_dones(20, nd);

        // Held high with incrementing input.
        @(negedge clock);
        start_i = 1'b1;
        nd = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clock);
            #1;
            if (done_o) nd++;
            bin_i = bin_i + 1'b1;
        end
        @(negedge clock);
        start_i = 1'b0;
        check("held_inc_dones", nd, 4);
        count_dones(20, nd);

        // Reset mid-conversion aborts with zeroed outputs.
        @(negedge clock);
        start_i = 1'b1;
        bin_i   = BW'(5678);
        @(negedge clock);
        start_i = 1'b0;
        repeat (6) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check_digits("rst", 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b1;
        count_dones(20, nd);
        check("rst_no_done", nd, 0);
        run_conv("v90", 90, 0, 0, 9, 0, 0);

        // Random values against div/mod digits.
        for (int i = 0; i < 1000; i++) begin
            v = int'($urandom_range(0, 16383));
            e = (v > 9999) ? 9999 : v;
            run_conv("rand", v, e / 1000, (e / 100) % 10, (e / 10) % 10, e % 10,
                     (v > 9999) ? 1 : 0);
        end

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
